nibble_serial_alu_seq: RTL and testbench

- Digit-serial sequencer that drives one external 4-bit sn74181 slice to run a WIDTH-bit ALU operation, one nibble per clock, LSB first.
- Sits directly upstream of the 74181: supplies operand nibbles, function select, mode and carry-in.
- Sits directly downstream as well: captures the slice's f, cn4_ and aeqb.
- Assembles the WIDTH-bit result, the ripple carry and the equality flag, with a start/busy/done handshake.

---
 rtl/nibble_serial_alu_seq.sv | 137 +++++++++++++
 tb/tb_nibble_serial_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_seq.sv
// nibble_serial_alu_seq: drives one external 74181 slice nibble by nibble, LSB first,
// and assembles the WIDTH-bit result, ripple carry and equality flag. Rev 1.0
`default_nettype none

module nibble_serial_alu_seq #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin_,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout_,
  output logic             aeqb,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn_,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4_,
  input  logic             alu_aeqb
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NIB-1:0][3:0] a_reg;
  logic [NIB-1:0][3:0] b_reg;
  logic [NIB-1:0][3:0] f_reg;
  logic [3:0]          s_reg;
  logic                m_reg;
  logic                carry_reg;
  logic                acc_reg;
  logic                cout_reg;
  logic                aeqb_reg;
  logic [IW-1:0]       idx;
  logic                last_step;

  assign last_step = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Flags are published on the final RUN edge so they hold their old values
  // throughout the next operation and are valid together with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      f_reg     <= '0;
      s_reg     <= '0;
      m_reg     <= 1'b0;
      carry_reg <= 1'b1;
      acc_reg   <= 1'b1;
      cout_reg  <= 1'b1;
      aeqb_reg  <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            s_reg     <= s;
            m_reg     <= m;
            carry_reg <= cin_;
            acc_reg   <= 1'b1;
            idx       <= '0;
          end
        end
        RUN: begin
          f_reg[idx] <= alu_f;
          acc_reg    <= acc_reg & alu_aeqb;
          // In logic mode cn4_ is meaningless and may be undriven.
          if (!m_reg) carry_reg <= alu_cn4_;
          if (last_step) begin
            idx      <= '0;
            aeqb_reg <= acc_reg & alu_aeqb;
            cout_reg <= m_reg ? 1'b1 : alu_cn4_;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a   = a_reg[idx];
  assign alu_b   = b_reg[idx];
  assign alu_s   = s_reg;
  assign alu_m   = m_reg;
  assign alu_cn_ = carry_reg;

  assign f     = f_reg;
  assign cout_ = cout_reg;
  assign aeqb  = aeqb_reg;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_alu_seq.sv
// tb_nibble_serial_alu_seq: sequencer wired to a behavioural 74181 slice, checked
// against a word-level 74181 function-table model. Rev 1.0
`default_nettype none

module tb_nibble_serial_alu_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       s;
  logic             m, cin_;
  logic             busy, done, cout_, aeqb;
  logic [WIDTH-1:0] f;
  logic [3:0]       alu_a, alu_b, alu_s, alu_f;
  logic             alu_m, alu_cn_, alu_cn4_, alu_aeqb;
  logic             junk = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic prev_cout = 1'b1;
  logic prev_aeqb = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin_(cin_),
    .busy(busy), .done(done), .f(f), .cout_(cout_), .aeqb(aeqb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn_(alu_cn_),
    .alu_f(alu_f), .alu_cn4_(alu_cn4_), .alu_aeqb(alu_aeqb)
  );

  // The external slice; cn4_ is random garbage in logic mode.
  logic [3:0] u4, v4;
  logic [4:0] s5;
  always_comb begin
    u4       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    v4       = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    s5       = {1'b0, u4} + {1'b0, v4} + {4'b0, ~alu_cn_};
    alu_f    = alu_m ? ~(u4 ^ v4) : s5[3:0];
    alu_cn4_ = alu_m ? junk : ~s5[4];
    alu_aeqb = &alu_f;
  end

  always @(posedge clk) junk <= 1'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns {cout_, aeqb, f} straight from the 74181 function table at word width.
  function automatic logic [WIDTH+1:0] ref_alu(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                               input logic [3:0] rs, input logic rm, input logic rcin_);
    logic [WIDTH-1:0] ones, x, y, fr;
    logic [WIDTH:0]   sum;
    logic             co_;
    ones = '1;
    x = '0; y = '0; co_ = 1'b1;
    if (rm) begin
      case (rs)
        4'd0:  fr = ~ra;          4'd1:  fr = ~(ra | rb);
        4'd2:  fr = ~ra & rb;     4'd3:  fr = '0;
        4'd4:  fr = ~(ra & rb);   4'd5:  fr = ~rb;
        4'd6:  fr = ra ^ rb;      4'd7:  fr = ra & ~rb;
        4'd8:  fr = ~ra | rb;     4'd9:  fr = ~(ra ^ rb);
        4'd10: fr = rb;           4'd11: fr = ra & rb;
        4'd12: fr = ones;         4'd13: fr = ra | ~rb;
        4'd14: fr = ra | rb;      default: fr = ra;
      endcase
    end else begin
      case (rs)
        4'd0:  begin x = ra;        y = '0;        end
        4'd1:  begin x = ra | rb;   y = '0;        end
        4'd2:  begin x = ra | ~rb;  y = '0;        end
        4'd3:  begin x = '0;        y = ones;      end
        4'd4:  begin x = ra;        y = ra & ~rb;  end
        4'd5:  begin x = ra | rb;   y = ra & ~rb;  end
        4'd6:  begin x = ra;        y = ~rb;       end
        4'd7:  begin x = ra & ~rb;  y = ones;      end
        4'd8:  begin x = ra;        y = ra & rb;   end
        4'd9:  begin x = ra;        y = rb;        end
        4'd10: begin x = ra | ~rb;  y = ra & rb;   end
        4'd11: begin x = ra & rb;   y = ones;      end
        4'd12: begin x = ra;        y = ra;        end
        4'd13: begin x = ra | rb;   y = ra;        end
        4'd14: begin x = ra | ~rb;  y = ra;        end
        default: begin x = ra;      y = ones;      end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ~rcin_};
      fr  = sum[WIDTH-1:0];
      co_ = ~sum[WIDTH];
    end
    return {co_, (fr == ones), fr};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic [3:0] os, input logic om, input logic ocin_, input bit glitch);
    logic [WIDTH+1:0] r;
    int cycles, busy_n;
    r = ref_alu(oa, ob, os, om, ocin_);
    @(negedge clk);
    a = oa; b = ob; s = os; m = om; cin_ = ocin_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); s = 4'($urandom); m = 1'($urandom); cin_ = 1'($urandom);
    chk("hold_cout_", 32'(cout_), 32'(prev_cout));
    chk("hold_aeqb", 32'(aeqb), 32'(prev_aeqb));
    cycles = 0;
    busy_n = 0;
    while (!done && cycles < 4 * NIB + 8) begin
      if (busy) busy_n++;
      if (glitch && cycles == 1) begin
        start = 1'b1;
        a = ~oa;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    chk("latency_edges", 32'(cycles + 1), 32'(NIB + 1));
    chk("busy_cycles", 32'(busy_n), 32'(NIB));
    chk("f", 32'(f), 32'(r[WIDTH-1:0]));
    chk("cout_", 32'(cout_), 32'(r[WIDTH+1]));
    chk("aeqb", 32'(aeqb), 32'(r[WIDTH]));
    if (glitch) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    prev_cout = r[WIDTH+1];
    prev_aeqb = r[WIDTH];
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin_ = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_cout_", 32'(cout_), 32'd1);
    chk("rst_aeqb", 32'(aeqb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_cn_}), 32'h0000_0001);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0005, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_op(16'hA5A5, 16'hA5A5, 4'b0110, 1'b0, 1'b1, 1'b0);
    run_op(16'hA5A4, 16'hA5A5, 4'b0110, 1'b0, 1'b1, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'($urandom), 1'b0);
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b1);

    // Reset abandoned mid-operation at nibble 2.
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; s = 4'b1001; m = 1'b0; cin_ = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_f", 32'(f), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_flags", 32'({cout_, aeqb, alu_cn_}), 32'b101);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);
    prev_cout = 1'b1;
    prev_aeqb = 1'b0;
    run_op(16'h5555, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
      run_op(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
